serializador: RTL and testbench
===============================

Name: serializador

Overview:
- Transmit-side counterpart of the deserializador: accepts parallel bytes from a producer, buffers them in a small FIFO and shifts each out bit-serially, MSB first.
- Serial output is a data_out bit qualified by a write_out strobe, cycle by cycle.
- Flow control: honours the downstream status_in (the deserializador's status_out) and only starts a new byte while status_in=0.
- Sits between the byte-producing logic and a deserializador on the same clock_100KHz domain.

Parameters:
- DATA_WIDTH, 8, bits per serial word (shift length and FIFO word width).
- FIFO_DEPTH, 4, number of buffered words (power of 2, >=2).

Ports:
- clock_100KHz  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  DATA_WIDTH  parallel word to transmit.
- write_in  input  1  push strobe; data_in captured at the edge when write_in=1 and full_out=0.
- full_out  output  1  FIFO holds FIFO_DEPTH words.
- overflow_out  output  1  one-cycle pulse: push attempted while full_out=1.
- status_in  input  1  downstream busy; 1 blocks the start of a new word.
- data_out  output  1  serial bit, valid when write_out=1.
- write_out  output  1  serial bit strobe.
- busy_out  output  1  1 while FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset (sync, reset=1 at edge) sets:
  - data_out=0, write_out=0, full_out=0, overflow_out=0, busy_out=0.
  - FIFO empty (pointers/count=0), bit counter=0, state=IDLE.
- Reset mid-word aborts the word immediately: write_out=0 after that edge, and buffered words are discarded.
- All outputs are registered; no combinational path from input to output.
- FIFO push:
  - When write_in=1 and full_out=0 at an edge, the word is stored and the count increments.
  - When write_in=1 and full_out=1, the word is dropped, the FIFO is unchanged and overflow_out=1 for the next cycle only.
  - full_out is evaluated on the registered count. A push is dropped when full_out=1, even if a pop occurs in the same cycle.
- FIFO pop happens only in IDLE as described below. Simultaneous push+pop with count<FIFO_DEPTH leaves the count unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: write_out=0. If FIFO non-empty and status_in=0, pop the head into the shift register, set the bit counter to DATA_WIDTH-1 and go to SEND. Otherwise stay in IDLE.
  - SEND: write_out=1 and data_out=shift[DATA_WIDTH-1] each cycle. Shift left one bit per cycle and decrement the counter. When the counter is 0 at the edge, go to GAP.
    - A word, once started, is always sent in DATA_WIDTH consecutive cycles; status_in is ignored during SEND.
  - GAP: exactly 1 cycle with write_out=0, data_out=0; then go to IDLE. This gives the receiver a word boundary and time to raise status_out.
- Timing:
  - A push at edge t into an empty idle block gives its first serial bit (write_out=1) in the cycle after edge t+2.
  - The word occupies DATA_WIDTH cycles, then 1 GAP cycle, then 1 IDLE cycle.
  - Back-to-back word period with status_in=0 is DATA_WIDTH+2 cycles.
- status_in sampled at 1 in IDLE holds the block in IDLE. The FIFO keeps accepting pushes until full.
- busy_out = (count!=0) or (state!=IDLE), registered.

Test Plan:
- Reset, push 0xA5 with status_in=0 → two cycles after the push edge, write_out=1 for 8 cycles carrying 1,0,1,0,0,1,0,1; then write_out=0; busy_out returns to 0.
- Push 0xFF, 0x00, 0x3C on consecutive cycles → three 8-bit bursts in order, each separated by write_out=0 for 2 cycles; the third burst carries 0,0,1,1,1,1,0,0.
- Hold status_in=1, push 5 words (0x01..0x05) → full_out=1 after the 4th push; the 5th push raises overflow_out for one cycle and is dropped. Release status_in → exactly 0x01..0x04 are sent.
- Raise status_in during bit 3 of 0xC3 → the word still completes all 8 bits. The next buffered word waits in IDLE until status_in=0.
- Assert reset during bit 4 of 0x96 with 2 words queued → write_out=0 on the next cycle, busy_out=0, and nothing is sent afterwards without new pushes.
- Loopback into a deserializador (data_out→data_in, write_out→write_in, status_out→status_in, ack pulsed after data_ready) with 0x5A then 0x81 → the deserializador's data_out shows 0x5A, then 0x81 after ack.

Source files
------------

// File: rtl/serializador.sv
// Byte-to-serial transmitter: a small FIFO feeds an MSB-first shifter that emits
// one word per DATA_WIDTH strobed cycles, followed by a one-cycle gap.
module serializador #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock_100KHz,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write_in,
  output logic                  full_out,
  output logic                  overflow_out,
  input  logic                  status_in,
  output logic                  data_out,
  output logic                  write_out,
  output logic                  busy_out
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg, count_next;
  logic [BIT_W-1:0]      bit_cnt_reg, bit_cnt_next;
  logic [1:0]            state_reg, state_next;
  logic                  push, pop;
  logic                  write_next, data_next;

  // Push is gated by the registered full flag, so a same-cycle pop never rescues it.
  assign push = write_in && !full_out;
  assign pop  = (state_reg == ST_IDLE) && (count_reg != '0) && !status_in;

  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + CNT_W'(1);
    else if (pop && !push)
      count_next = count_reg - CNT_W'(1);
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    write_next   = 1'b0;
    data_next    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (pop) begin
          bit_cnt_next = BIT_W'(DATA_WIDTH - 1);
          state_next   = ST_SEND;
        end
      end
      ST_SEND: begin
        write_next   = 1'b1;
        data_next    = shift_reg[DATA_WIDTH-1];
        bit_cnt_next = bit_cnt_reg - BIT_W'(1);
        if (bit_cnt_reg == '0)
          state_next = ST_GAP;
      end
      ST_GAP:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Storage and shifter carry no reset: their contents are only observed once
  // the control path has validated them.
  always_ff @(posedge clock_100KHz) begin
    if (push)
      mem[wr_ptr_reg] <= data_in;
    if (pop)
      shift_reg <= mem[rd_ptr_reg];
    else if (state_reg == ST_SEND)
      shift_reg <= shift_reg << 1;
  end

  always_ff @(posedge clock_100KHz) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      bit_cnt_reg  <= '0;
      state_reg    <= ST_IDLE;
      full_out     <= 1'b0;
      overflow_out <= 1'b0;
      data_out     <= 1'b0;
      write_out    <= 1'b0;
      busy_out     <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg    <= count_next;
      bit_cnt_reg  <= bit_cnt_next;
      state_reg    <= state_next;
      full_out     <= (count_next == CNT_W'(FIFO_DEPTH));
      overflow_out <= write_in && full_out;
      data_out     <= data_next;
      write_out    <= write_next;
      busy_out     <= (count_next != '0) || (state_next != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_serializador.sv
// Directed bench for serializador, including a small receiver model used for
// the loopback scenario.
module tb_serializador;

  logic       clock_100KHz;
  logic       reset;
  logic [7:0] data_in;
  logic       write_in;
  logic       full_out;
  logic       overflow_out;
  logic       status_in;
  logic       data_out;
  logic       write_out;
  logic       busy_out;

  logic       status_drv;
  logic       loop_mode;
  logic       des_status;
  logic       des_ready;
  logic       des_ack;
  logic [7:0] des_shift;
  logic [7:0] des_data;
  logic [2:0] des_cnt;

  int total = 0;
  int bad   = 0;

  serializador #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clock_100KHz (clock_100KHz),
    .reset        (reset),
    .data_in      (data_in),
    .write_in     (write_in),
    .full_out     (full_out),
    .overflow_out (overflow_out),
    .status_in    (status_in),
    .data_out     (data_out),
    .write_out    (write_out),
    .busy_out     (busy_out)
  );

  assign status_in = loop_mode ? des_status : status_drv;

  initial clock_100KHz = 1'b0;
  always #5 clock_100KHz = ~clock_100KHz;

  // Receiver model: collects 8 strobed bits, then holds status until ack.
  always @(posedge clock_100KHz) begin
    if (reset) begin
      des_cnt    <= 3'd0;
      des_ready  <= 1'b0;
      des_status <= 1'b0;
      des_shift  <= 8'h00;
      des_data   <= 8'h00;
    end else begin
      if (des_ack) begin
        des_ready  <= 1'b0;
        des_status <= 1'b0;
      end
      if (write_out === 1'b1) begin
        des_shift <= {des_shift[6:0], data_out};
        if (des_cnt == 3'd7) begin
          des_data   <= {des_shift[6:0], data_out};
          des_ready  <= 1'b1;
          des_status <= 1'b1;
          des_cnt    <= 3'd0;
        end else begin
          des_cnt <= des_cnt + 3'd1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock_100KHz);
    #1;
  endtask

  task automatic push_word(input logic [7:0] w);
    data_in  = w;
    write_in = 1'b1;
    tick();
    write_in = 1'b0;
  endtask

  // Waits (bounded) for a strobe, then gathers the consecutive strobed bits.
  task automatic recv_word(input int raise_at, output logic [7:0] w,
                           output int waited, output int len);
    waited = 0;
    while (write_out !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    w   = 8'h00;
    len = 0;
    while (write_out === 1'b1 && len < 12) begin
      w = {w[6:0], data_out};
      if (len == raise_at) status_drv = 1'b1;
      len++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++;
    if ({write_out, data_out, full_out, overflow_out, busy_out} !== 5'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=00000",
               {write_out, data_out, full_out, overflow_out, busy_out});
    end
  endtask

  task automatic test_single();
    logic [7:0] w;
    int waited, len;
    push_word(8'hA5);
    total++;
    if (busy_out !== 1'b1) begin
      bad++; $display("FAIL single_busy got=%b want=1", busy_out);
    end
    recv_word(-1, w, waited, len);
    total++;
    if (waited !== 2) begin
      bad++; $display("FAIL single_latency got=%0d want=2", waited);
    end
    total++;
    if (len !== 8 || w !== 8'hA5) begin
      bad++; $display("FAIL single_word got=%h/%0d want=a5/8", w, len);
    end
    total++;
    if (busy_out !== 1'b0 || write_out !== 1'b0 || data_out !== 1'b0) begin
      bad++; $display("FAIL single_end got=%b%b%b want=000", busy_out, write_out, data_out);
    end
    $display("single: word=%h len=%0d latency=%0d", w, len, waited);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    logic [7:0] w;
    int waited, len;
    exp[0] = 8'hFF; exp[1] = 8'h00; exp[2] = 8'h3C;
    data_in = 8'hFF; write_in = 1'b1; tick();
    data_in = 8'h00; tick();
    data_in = 8'h3C; tick();
    write_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      recv_word(-1, w, waited, len);
      total++;
      if (w !== exp[i] || len !== 8) begin
        bad++; $display("FAIL b2b_word%0d got=%h/%0d want=%h/8", i, w, len, exp[i]);
      end
      if (i > 0) begin
        total++;
        if (waited !== 2) begin
          bad++; $display("FAIL b2b_gap%0d got=%0d want=2", i, waited);
        end
      end
      $display("b2b: word%0d=%h len=%0d gap=%0d", i, w, len, waited);
    end
    total++;
    if (busy_out !== 1'b0) begin
      bad++; $display("FAIL b2b_idle got=%b want=0", busy_out);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] w;
    int waited, len;
    status_drv = 1'b1;
    write_in   = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      data_in = 8'(i);
      tick();
      total++;
      if (full_out !== (i == 4)) begin
        bad++; $display("FAIL ovf_full%0d got=%b want=%b", i, full_out, (i == 4));
      end
    end
    data_in = 8'h05;
    tick();
    write_in = 1'b0;
    total++;
    if (overflow_out !== 1'b1) begin
      bad++; $display("FAIL ovf_pulse got=%b want=1", overflow_out);
    end
    tick();
    total++;
    if (overflow_out !== 1'b0 || full_out !== 1'b1 || write_out !== 1'b0) begin
      bad++; $display("FAIL ovf_after got=%b%b%b want=010", overflow_out, full_out, write_out);
    end
    status_drv = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      recv_word(-1, w, waited, len);
      total++;
      if (w !== 8'(i) || len !== 8) begin
        bad++; $display("FAIL ovf_word%0d got=%h/%0d want=%h/8", i, w, len, 8'(i));
      end
      $display("overflow: word%0d=%h", i, w);
    end
    recv_word(-1, w, waited, len);
    total++;
    if (len !== 0) begin
      bad++; $display("FAIL ovf_extra got_len=%0d want=0", len);
    end
  endtask

  task automatic test_status_mid();
    logic [7:0] w;
    int waited, len, strobes;
    status_drv = 1'b0;
    data_in = 8'hC3; write_in = 1'b1; tick();
    data_in = 8'h5A; tick();
    write_in = 1'b0;
    recv_word(3, w, waited, len);
    total++;
    if (w !== 8'hC3 || len !== 8) begin
      bad++; $display("FAIL stmid_word got=%h/%0d want=c3/8", w, len);
    end
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      if (write_out === 1'b1) strobes++;
      tick();
    end
    total++;
    if (strobes !== 0 || busy_out !== 1'b1) begin
      bad++; $display("FAIL stmid_hold got=%0d/%b want=0/1", strobes, busy_out);
    end
    status_drv = 1'b0;
    recv_word(-1, w, waited, len);
    total++;
    if (w !== 8'h5A || len !== 8 || waited !== 2) begin
      bad++; $display("FAIL stmid_next got=%h/%0d/%0d want=5a/8/2", w, len, waited);
    end
    $display("status_mid: resumed word=%h latency=%0d", w, waited);
  endtask

  task automatic test_reset_mid();
    logic [7:0] w;
    logic [3:0] head;
    int waited, len;
    data_in = 8'h96; write_in = 1'b1; tick();
    data_in = 8'h11; tick();
    data_in = 8'h22; tick();
    write_in = 1'b0;
    waited = 0;
    while (write_out !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    head = 4'h0;
    for (int i = 0; i < 4; i++) begin
      head = {head[2:0], data_out};
      tick();
    end
    total++;
    if (head !== 4'b1001) begin
      bad++; $display("FAIL rstmid_head got=%b want=1001", head);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({write_out, busy_out, full_out, data_out} !== 4'b0) begin
      bad++; $display("FAIL rstmid_abort got=%b want=0000",
                      {write_out, busy_out, full_out, data_out});
    end
    recv_word(-1, w, waited, len);
    total++;
    if (len !== 0) begin
      bad++; $display("FAIL rstmid_silent got_len=%0d want=0", len);
    end
    $display("reset_mid: head=%b strobes_after=%0d", head, len);
  endtask

  task automatic test_loopback();
    int n, strobes;
    reset = 1'b1; tick(); reset = 1'b0;
    loop_mode = 1'b1;
    data_in = 8'h5A; write_in = 1'b1; tick();
    data_in = 8'h81; tick();
    write_in = 1'b0;
    n = 0;
    while (des_ready !== 1'b1 && n < 100) begin tick(); n++; end
    total++;
    if (n >= 100 || des_data !== 8'h5A) begin
      bad++; $display("FAIL loop_first got=%h wait=%0d want=5a", des_data, n);
    end
    strobes = 0;
    for (int i = 0; i < 5; i++) begin
      if (write_out === 1'b1) strobes++;
      tick();
    end
    total++;
    if (strobes !== 0) begin
      bad++; $display("FAIL loop_hold got=%0d want=0", strobes);
    end
    des_ack = 1'b1; tick(); des_ack = 1'b0;
    n = 0;
    while (des_ready !== 1'b1 && n < 100) begin tick(); n++; end
    total++;
    if (n >= 100 || des_data !== 8'h81) begin
      bad++; $display("FAIL loop_second got=%h wait=%0d want=81", des_data, n);
    end
    $display("loopback: second word=%h", des_data);
    des_ack = 1'b1; tick(); des_ack = 1'b0;
    loop_mode = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    data_in    = 8'h00;
    write_in   = 1'b0;
    status_drv = 1'b0;
    loop_mode  = 1'b0;
    des_ack    = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_status_mid();
    test_reset_mid();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
